// File: rtl/uart_tx_arbiter_if.sv
// Requester, transmitter and grant-status signals of the UART transmit arbiter.
// The slave side is the arbiter. The master side is the requesters plus the transmitter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   last;
  logic [8*NUM_REQ-1:0] data;
  logic [NUM_REQ-1:0]   ack;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic                 grant_valid;
  logic [ID_W-1:0]      grant_id;
  logic                 timeout_err;

  modport master (
    output req, last, data, tx_busy,
    input  ack, tx_data, tx_start, grant_valid, grant_id, timeout_err
  );

  modport slave (
    input  req, last, data, tx_busy,
    output ack, tx_data, tx_start, grant_valid, grant_id, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular sharing of one UART transmitter. All outputs are registered.
// Latency is 2 cycles from req to tx_start. A requester is stalled by holding off ack until the transmitter is idle.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 16,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic               grant_valid_q, grant_valid_d;
  logic [7:0]         burst_cnt_q, burst_cnt_d;
  logic [7:0]         tmo_cnt_q, tmo_cnt_d;
  logic               last_flag_q, last_flag_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               timeout_err_q, timeout_err_d;

  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    cand_id;
  logic [ID_W-1:0]    next_id;
  logic               rel;
  int                 cand;

  // Search for the winner starting at rr_ptr and wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    cand_id   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_id = ID_W'(cand);
      if (!win_found && bus.req[cand_id]) begin
        win_found = 1'b1;
        win_id    = cand_id;
      end
    end
  end

  assign next_id = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    burst_cnt_d   = burst_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    last_flag_d   = last_flag_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    ack_d         = '0;
    timeout_err_d = 1'b0;
    rel           = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_id_d    = win_id;
          grant_valid_d = 1'b1;
          burst_cnt_d   = '0;
          state_d       = SEND;
        end
      end
      SEND: begin
        // A dropped req while owning the grant means the message was abandoned.
        if (!bus.req[grant_id_q]) begin
          rel = 1'b1;
        end else if (!bus.tx_busy) begin
          tx_start_d         = 1'b1;
          ack_d[grant_id_q]  = 1'b1;
          tx_data_d          = bus.data[{grant_id_q, 3'b000} +: 8];
          last_flag_d        = bus.last[grant_id_q];
          burst_cnt_d        = burst_cnt_q + 8'd1;
          tmo_cnt_d          = '0;
          state_d            = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_cnt_q + 8'd1 == 8'(ACK_TIMEOUT)) begin
          timeout_err_d = 1'b1;
          rel           = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (last_flag_q || burst_cnt_q == 8'(MAX_BURST)) rel = 1'b1;
          else state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rel) begin
      grant_valid_d = 1'b0;
      rr_ptr_d      = next_id;
      state_d       = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      burst_cnt_q   <= '0;
      tmo_cnt_q     <= '0;
      last_flag_q   <= 1'b0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      ack_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      burst_cnt_q   <= burst_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      last_flag_q   <= last_flag_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      ack_q         <= ack_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester and transmitter models, plus a scoreboard of expected issues, timeouts and grants.
module tb_uart_tx_arbiter;
  localparam int NR    = 4;
  localparam int MB    = 3;
  localparam int AT    = 8;
  localparam int FRAME = 10;
  localparam int EV_ISSUE = 0;
  localparam int EV_TMO   = 1;

  typedef struct {
    int kind;
    int id;
    int dat;
  } ev_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NR), .MAX_BURST(MB), .ACK_TIMEOUT(AT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  ev_t exp_ev[$];
  int  exp_gnt[$];

  logic [8:0]    rmem[NR][32];
  int            rhead[NR];
  int            rtail[NR];
  logic [NR-1:0] pulse_req;
  bit            stuck;
  int            busy_left;
  logic [NR-1:0]   rq, lv;
  logic [8*NR-1:0] dv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input logic l);
    rmem[r][rtail[r]] = {l, d};
    rtail[r]++;
  endtask

  task automatic exp_issue(input int id, input int d);
    ev_t e;
    e.kind = EV_ISSUE; e.id = id; e.dat = d;
    exp_ev.push_back(e);
  endtask

  task automatic exp_timeout();
    ev_t e;
    e.kind = EV_TMO; e.id = 0; e.dat = 0;
    exp_ev.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    int stable;
    bit pend;
    stable = 0;
    for (int n = 0; n < budget && stable < 4; n++) begin
      @(negedge clk);
      pend = 1'b0;
      for (int i = 0; i < NR; i++) if (rhead[i] != rtail[i]) pend = 1'b1;
      if (exp_ev.size() == 0 && exp_gnt.size() == 0 && !bus.grant_valid && !bus.tx_busy && !pend)
        stable++;
      else
        stable = 0;
    end
    if (stable < 4) chk({name, "_drain_timeout"}, stable, 4);
  endtask

  // Requesters and transmitter, all driven on the falling edge.
  initial begin : driver
    bus.req = '0; bus.last = '0; bus.data = '0; bus.tx_busy = 1'b0;
    busy_left = 0;
    forever begin
      @(negedge clk);
      if (!reset) busy_left = 0;
      else if (bus.tx_start && !stuck) busy_left = FRAME;
      else if (busy_left > 0) busy_left--;
      bus.tx_busy = (busy_left != 0) && !stuck;
      rq = '0; lv = '0; dv = '0;
      for (int i = 0; i < NR; i++) begin
        if (bus.ack[i] && rhead[i] != rtail[i]) rhead[i]++;
        rq[i] = (rhead[i] != rtail[i]) || pulse_req[i];
        if (rhead[i] != rtail[i]) begin
          dv[8*i +: 8] = rmem[i][rhead[i]][7:0];
          lv[i]        = rmem[i][rhead[i]][8];
        end
      end
      pulse_req = '0;
      bus.req  = rq;
      bus.last = lv;
      bus.data = dv;
    end
  end

  initial begin : monitor
    int  cyc;
    int  last_start;
    bit  prev_gv;
    ev_t e;
    cyc = 0; last_start = 0; prev_gv = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.tx_start || bus.timeout_err || bus.ack != '0) begin
        if (exp_ev.size() == 0) begin
          chk("unexpected_event", {bus.tx_start, bus.timeout_err, bus.ack}, 0);
        end else begin
          e = exp_ev.pop_front();
          if (e.kind == EV_ISSUE) begin
            chk("issue_tx_start", bus.tx_start, 1);
            chk("issue_tx_data", bus.tx_data, e.dat);
            chk("issue_ack", bus.ack, 1 << e.id);
            chk("issue_grant_id", bus.grant_id, e.id);
            last_start = cyc;
          end else begin
            chk("timeout_pulse", bus.timeout_err, 1);
            chk("timeout_delay", cyc - last_start, AT);
            chk("timeout_no_ack", bus.ack, 0);
          end
        end
      end
      if (bus.grant_valid && !prev_gv) begin
        if (exp_gnt.size() == 0) chk("unexpected_grant", bus.grant_valid, 0);
        else chk("grant_order", bus.grant_id, exp_gnt.pop_front());
      end
      prev_gv = bus.grant_valid;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    stuck = 1'b0;
    pulse_req = '0;
    for (int i = 0; i < NR; i++) begin rhead[i] = 0; rtail[i] = 0; end
    #1 reset = 1'b0;
    #1 chk("reset_outputs", {bus.grant_valid, bus.tx_start, bus.timeout_err, bus.ack, bus.tx_data, bus.grant_id}, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    // Single requester, two-byte message. The pointer ends up at 3.
    @(posedge clk); #1;
    exp_gnt.push_back(2);
    exp_issue(2, 'hA5); exp_issue(2, 'h3C);
    push_byte(2, 8'hA5, 1'b0); push_byte(2, 8'h3C, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("t1_grant_valid_c1", bus.grant_valid, 1);
    chk("t1_grant_id_c1", bus.grant_id, 2);
    chk("t1_no_start_c1", bus.tx_start, 0);
    @(negedge clk);
    chk("t1_start_c2", bus.tx_start, 1);
    chk("t1_data_c2", bus.tx_data, 'hA5);
    drain("t1", 200);

    // All four requesting. Since the pointer starts at 3, the order is 3,0,1,2,3.
    @(posedge clk); #1;
    exp_gnt.push_back(3); exp_gnt.push_back(0); exp_gnt.push_back(1);
    exp_gnt.push_back(2); exp_gnt.push_back(3);
    exp_issue(3, 'h13); exp_issue(0, 'h10); exp_issue(1, 'h11);
    exp_issue(2, 'h12); exp_issue(3, 'h23);
    push_byte(0, 8'h10, 1'b1); push_byte(1, 8'h11, 1'b1); push_byte(2, 8'h12, 1'b1);
    push_byte(3, 8'h13, 1'b1); push_byte(3, 8'h23, 1'b1);
    drain("t2", 400);

    // Burst cap of 3: requester 1 streams 5 bytes without last, interleaved with requester 0.
    @(posedge clk); #1;
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(0); exp_gnt.push_back(1);
    exp_issue(0, 'h40); exp_issue(1, 'h51); exp_issue(1, 'h52); exp_issue(1, 'h53);
    exp_issue(0, 'h41); exp_issue(1, 'h54); exp_issue(1, 'h55);
    push_byte(0, 8'h40, 1'b1); push_byte(0, 8'h41, 1'b1);
    for (int b = 1; b <= 5; b++) push_byte(1, 8'h50 + 8'(b), 1'b0);
    drain("t3", 600);

    // Stuck transmitter, starting with the pointer at 2.
    @(posedge clk); #1;
    stuck = 1'b1;
    exp_gnt.push_back(2); exp_gnt.push_back(3);
    exp_issue(2, 'h62); exp_timeout(); exp_issue(3, 'h73); exp_timeout();
    push_byte(2, 8'h62, 1'b1); push_byte(3, 8'h73, 1'b1);
    drain("t4", 200);
    stuck = 1'b0;

    // Abandon: req pulses for one cycle, so the grant is released in SEND without an issue.
    @(posedge clk); #1;
    exp_gnt.push_back(1);
    pulse_req[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_grant", bus.grant_valid, 1);
    @(negedge clk);
    chk("t5_release", bus.grant_valid, 0);
    chk("t5_no_start", {bus.tx_start, bus.ack}, 0);
    drain("t5", 100);

    // Reset during WAIT_DONE.
    @(posedge clk); #1;
    exp_gnt.push_back(0);
    exp_issue(0, 'h80);
    push_byte(0, 8'h80, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tx_start && n < 50);
    if (!bus.tx_start) chk("t6_start_seen", bus.tx_start, 1);
    repeat (4) @(negedge clk);
    chk("t6_busy_before_reset", bus.tx_busy, 1);
    reset = 1'b0;
    #1 chk("t6_reset_outputs", {bus.grant_valid, bus.tx_start, bus.timeout_err, bus.ack, bus.tx_data, bus.grant_id}, 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    exp_gnt.push_back(3);
    exp_issue(3, 'h93);
    push_byte(3, 8'h93, 1'b1);
    drain("t6", 200);

    chk("leftover_events", exp_ev.size(), 0);
    chk("leftover_grants", exp_gnt.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
